// File: rtl/beam_event_ctrl.sv
// Break-beam sensor controller: synchronises and debounces each beam on a
// divided sample tick, turns debounced breaks into pending events and
// serialises them round-robin onto one valid/ready event port.
module beam_event_ctrl #(
    parameter int   NUM_BEAMS    = 4,
    parameter int   TICK_DIV     = 50000,
    parameter int   DEBOUNCE_N   = 3,
    parameter logic BROKEN_LEVEL = 1'b0,
    parameter int   CNT_W        = 16,
    localparam int  ID_W         = (NUM_BEAMS > 1) ? $clog2(NUM_BEAMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_BEAMS-1:0] beam,
    input  logic                 evt_ready,
    output logic                 evt_valid,
    output logic [ID_W-1:0]      evt_id,
    output logic [NUM_BEAMS-1:0] beam_broken,
    output logic [NUM_BEAMS-1:0] led_toggle,
    output logic                 run_led,
    output logic [CNT_W-1:0]     break_count,
    output logic                 overflow
);

    localparam int PRE_W = $clog2(TICK_DIV);

    logic [NUM_BEAMS-1:0] sync_p0, sync_p1;
    logic [PRE_W-1:0]     pre_cnt;
    logic                 tick;
    logic [3:0]           run_cnt  [NUM_BEAMS];
    logic [3:0]           run_next [NUM_BEAMS];
    logic [NUM_BEAMS-1:0] bb_next, rise;
    logic [NUM_BEAMS-1:0] pending, grant_mask;
    logic [ID_W-1:0]      rr_ptr, winner;
    logic                 grant;

    // Number of simultaneous breaks in one cycle (up to 16 channels).
    function automatic logic [4:0] popcnt(input logic [NUM_BEAMS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NUM_BEAMS; i++) n = n + 5'(v[i]);
        return n;
    endfunction

    // Counter add that pins at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [4:0] b);
        logic [CNT_W+4:0] s;
        s = {5'b0, a} + {{CNT_W{1'b0}}, b};
        return (s > {5'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Two-flop synchroniser; idles at the "beam intact" level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= {NUM_BEAMS{~BROKEN_LEVEL}};
            sync_p1 <= {NUM_BEAMS{~BROKEN_LEVEL}};
        end else begin
            sync_p0 <= beam;
            sync_p1 <= sync_p0;
        end
    end

    assign tick = enable && (pre_cnt == PRE_W'(TICK_DIV - 1));

    // Sample-tick prescaler; held at zero while sampling is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                pre_cnt <= '0;
        else if (!enable || tick)  pre_cnt <= '0;
        else                       pre_cnt <= pre_cnt + 1'b1;
    end

    // Debounce: count consecutive ticks disagreeing with the debounced state.
    always_comb begin
        logic smp;
        smp     = 1'b0;
        bb_next = beam_broken;
        for (int i = 0; i < NUM_BEAMS; i++) begin
            run_next[i] = run_cnt[i];
            smp = (sync_p1[i] == BROKEN_LEVEL);
            if (!enable) begin
                run_next[i] = '0;
            end else if (tick) begin
                if (smp == beam_broken[i]) begin
                    run_next[i] = '0;
                end else if (run_cnt[i] == 4'(DEBOUNCE_N - 1)) begin
                    run_next[i] = '0;
                    bb_next[i]  = smp;
                end else begin
                    run_next[i] = run_cnt[i] + 4'd1;
                end
            end
        end
        rise = bb_next & ~beam_broken;
    end

    // Round-robin pick: nearest pending channel after the last winner.
    always_comb begin
        int best, d;
        best       = NUM_BEAMS;
        d          = 0;
        winner     = '0;
        grant_mask = '0;
        for (int i = 0; i < NUM_BEAMS; i++) begin
            d = (i - int'(rr_ptr) - 1 + 2 * NUM_BEAMS) % NUM_BEAMS;
            if (pending[i] && d < best) begin
                best   = d;
                winner = ID_W'(i);
            end
        end
        grant = (|pending) && (!evt_valid || evt_ready);
        if (grant) grant_mask[winner] = 1'b1;
    end

    // Debounced state, break bookkeeping and pending set (set beats grant).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BEAMS; i++) run_cnt[i] <= '0;
            beam_broken <= '0;
            led_toggle  <= '0;
            break_count <= '0;
            overflow    <= 1'b0;
            pending     <= '0;
        end else begin
            for (int i = 0; i < NUM_BEAMS; i++) run_cnt[i] <= run_next[i];
            beam_broken <= bb_next;
            led_toggle  <= led_toggle ^ rise;
            break_count <= sat_add(break_count, popcnt(rise));
            overflow    <= overflow | (|(rise & pending & ~grant_mask));
            pending     <= (pending & ~grant_mask) | rise;
        end
    end

    // Event slot: load on grant, empty on a handshake with nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_ptr    <= ID_W'(NUM_BEAMS - 1);
        end else if (grant) begin
            evt_valid <= 1'b1;
            evt_id    <= winner;
            rr_ptr    <= winner;
        end else if (evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

    // Run indicator mirrors enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_led <= 1'b0;
        else        run_led <= enable;
    end

endmodule
